// File: rtl/peak_hold_pkg.sv
// peak_hold_pkg: shared constants, state encoding and index-width helper for peak_hold_4bit
package peak_hold_pkg;
  localparam int DATA_W = 4;
  localparam int WIN_LEN_MIN = 2;
  localparam int WIN_LEN_MAX = 256;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t HOLD  = 2'd2;
  // window length is clamped into the legal range before sizing index/counter
  function automatic int idx_w(input int win);
    return $clog2(win < WIN_LEN_MIN ? WIN_LEN_MIN : win > WIN_LEN_MAX ? WIN_LEN_MAX : win);
  endfunction
endpackage

// File: rtl/peak_hold_4bit_if.sv
// peak_hold_4bit_if: sample-in / result-out valid-ready bundle for peak_hold_4bit
//   in_valid/in_data/in_ready    : sample stream into the detector
//   out_valid/out_peak/out_idx/out_ready : window result stream
//   out_min only exists when PEAK_HOLD_MIN_EN is defined
interface peak_hold_4bit_if #(parameter int WIN_LEN = 16);
  import peak_hold_pkg::*;
  localparam int IDX_W = idx_w(WIN_LEN);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_peak;
  logic [IDX_W-1:0]  out_idx;
  logic              out_ready;
`ifdef PEAK_HOLD_MIN_EN
  logic [DATA_W-1:0] out_min;
`endif
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_peak, out_idx
`ifdef PEAK_HOLD_MIN_EN
    , out_min
`endif
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_peak, out_idx
`ifdef PEAK_HOLD_MIN_EN
    , out_min
`endif
  );
endinterface

// File: rtl/greater_than_4bit.sv
// greater_than_4bit: gate-level unsigned 4-bit comparator, gt = (a > b)
//   a, b : 4-bit unsigned operands
//   gt   : 1 when a is strictly greater than b
module greater_than_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt
);
  logic [3:0] eq;
  logic [3:0] g;
  assign eq = ~(a ^ b);
  assign g  = a & ~b;
  // MSB-first priority: a bit decides only if every higher bit is equal
  assign gt = g[3]
            | (eq[3] & g[2])
            | (eq[3] & eq[2] & g[1])
            | (eq[3] & eq[2] & eq[1] & g[0]);
endmodule

// File: rtl/peak_hold_4bit.sv
// peak_hold_4bit: windowed peak detector (max value + first index) over WIN_LEN 4-bit samples
//   clk, rst_n (async active-low), clear (sync abort)
//   bus  : peak_hold_4bit_if slave (sample in, result out)
//   busy : window in progress
//   PEAK_HOLD_MIN_EN adds out_min, tracked by a second comparator
module peak_hold_4bit #(parameter int WIN_LEN = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  peak_hold_4bit_if.slave  bus,
  output logic             busy
);
  import peak_hold_pkg::*;
  localparam int IDX_W = idx_w(WIN_LEN);
  state_t            state;
  logic [DATA_W-1:0] peak;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  cnt;
  logic              gt;
  logic              take;
  logic              last;
  greater_than_4bit u_gt (.a(bus.in_data), .b(peak), .gt(gt));
  assign take          = bus.in_valid & bus.in_ready;
  assign last          = cnt == IDX_W'(WIN_LEN - 1);
  assign bus.in_ready  = state != HOLD;
  assign bus.out_valid = state == HOLD;
  assign bus.out_peak  = peak;
  assign bus.out_idx   = idx;
  assign busy          = state == ACCUM;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      peak  <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else if (clear) begin
      state <= IDLE;
      peak  <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (take) begin
        state <= ACCUM;
        peak  <= bus.in_data;
        idx   <= '0;
        cnt   <= IDX_W'(1);
      end
    end else if (state == ACCUM) begin
      if (take) begin
        // strict greater-than: ties keep the earliest index
        if (gt) begin
          peak <= bus.in_data;
          idx  <= cnt;
        end
        cnt <= last ? cnt : cnt + 1'b1;
        if (last) state <= HOLD;
      end
    end else if (bus.out_ready) begin
      state <= IDLE;
    end
`ifdef PEAK_HOLD_MIN_EN
  logic [DATA_W-1:0] mn;
  logic              lt;
  // min > in_data is exactly in_data < min, so only strict decreases update
  greater_than_4bit u_lt (.a(mn), .b(bus.in_data), .gt(lt));
  assign bus.out_min = mn;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mn <= '0;
    else if (clear) mn <= '0;
    else if (take && (state == IDLE || lt)) mn <= bus.in_data;
`endif
endmodule

// File: tb/tb_peak_hold_4bit.sv
// tb_peak_hold_4bit: randomized self-checking bench for peak_hold_4bit (WIN_LEN=4 and WIN_LEN=2)
module tb_peak_hold_4bit;
  import peak_hold_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic clear = 0;
  logic busy4, busy2;
  int checks = 0;
  int errors = 0;
  peak_hold_4bit_if #(.WIN_LEN(4)) a4();
  peak_hold_4bit_if #(.WIN_LEN(2)) a2();
  peak_hold_4bit #(.WIN_LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(a4), .busy(busy4));
  peak_hold_4bit #(.WIN_LEN(2)) dut2 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(a2), .busy(busy2));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [3:0] d);
    a4.in_valid = 1;
    a4.in_data = d;
    tick;
    a4.in_valid = 0;
  endtask

  // reference: max of the window, first position holding it, min of the window
  function automatic void ref_win(input logic [3:0] s[$], output logic [3:0] pk, output int ix, output logic [3:0] mn);
    pk = 0;
    mn = 15;
    ix = -1;
    foreach (s[i]) begin
      if (s[i] > pk) pk = s[i];
      if (s[i] < mn) mn = s[i];
    end
    foreach (s[i]) if (ix < 0 && s[i] == pk) ix = i;
  endfunction

  task automatic test_reset;
    a4.in_valid = 0; a4.in_data = 0; a4.out_ready = 0;
    a2.in_valid = 0; a2.in_data = 0; a2.out_ready = 0;
    rst_n = 0;
    repeat (3) tick;
    checks++;
    if (a4.in_ready !== 1 || a4.out_valid !== 0 || busy4 !== 0 || a4.out_peak !== 0 || a4.out_idx !== 0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b peak=%0d idx=%0d, want 1 0 0 0 0", a4.in_ready, a4.out_valid, busy4, a4.out_peak, a4.out_idx);
    end
`ifdef PEAK_HOLD_MIN_EN
    checks++;
    if (a4.out_min !== 0) begin errors++; $display("FAIL reset_min: got %0d want 0", a4.out_min); end
`endif
    rst_n = 1;
    tick;
  endtask

  task automatic test_tie;
    a4.out_ready = 1;
    send4(3); send4(9); send4(9);
    checks++;
    if (a4.out_valid !== 0 || busy4 !== 1) begin errors++; $display("FAIL tie_early: vld=%b busy=%b want 0 1", a4.out_valid, busy4); end
    send4(2);
    checks++;
    if (a4.out_valid !== 1 || a4.out_peak !== 9 || a4.out_idx !== 1) begin
      errors++;
      $display("FAIL tie_result: vld=%b peak=%0d idx=%0d want 1 9 1", a4.out_valid, a4.out_peak, a4.out_idx);
    end
    tick;
    checks++;
    if (a4.out_valid !== 0 || a4.in_ready !== 1) begin errors++; $display("FAIL tie_drain: vld=%b rdy=%b want 0 1", a4.out_valid, a4.in_ready); end
  endtask

  task automatic test_zeros;
    a4.out_ready = 1;
    repeat (4) send4(0);
    checks++;
    if (a4.out_valid !== 1 || a4.out_peak !== 0 || a4.out_idx !== 0) begin
      errors++;
      $display("FAIL zeros: vld=%b peak=%0d idx=%0d want 1 0 0", a4.out_valid, a4.out_peak, a4.out_idx);
    end
    tick;
`ifdef PEAK_HOLD_MIN_EN
    send4(5); send4(15); send4(1); send4(7);
    checks++;
    if (a4.out_valid !== 1 || a4.out_peak !== 15 || a4.out_idx !== 1 || a4.out_min !== 1) begin
      errors++;
      $display("FAIL min_window: vld=%b peak=%0d idx=%0d min=%0d want 1 15 1 1", a4.out_valid, a4.out_peak, a4.out_idx, a4.out_min);
    end
    tick;
`endif
  endtask

  task automatic test_backpressure;
    a4.out_ready = 0;
    send4(7); send4(3); send4(12); send4(1);
    for (int i = 0; i < 5; i++) begin
      a4.in_valid = 1;
      a4.in_data = 15;
      checks++;
      if (a4.out_valid !== 1 || a4.out_peak !== 12 || a4.out_idx !== 2 || a4.in_ready !== 0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b peak=%0d idx=%0d rdy=%b want 1 12 2 0", i, a4.out_valid, a4.out_peak, a4.out_idx, a4.in_ready);
      end
      tick;
    end
    a4.in_valid = 0;
    a4.out_ready = 1;
    tick;
    checks++;
    if (a4.out_valid !== 0 || a4.in_ready !== 1 || busy4 !== 0) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b want 0 1 0", a4.out_valid, a4.in_ready, busy4);
    end
    repeat (4) send4(1);
    checks++;
    if (a4.out_valid !== 1 || a4.out_peak !== 1 || a4.out_idx !== 0) begin
      errors++;
      $display("FAIL bp_next: vld=%b peak=%0d idx=%0d want 1 1 0", a4.out_valid, a4.out_peak, a4.out_idx);
    end
    tick;
  endtask

  task automatic test_clear;
    a4.out_ready = 1;
    send4(5); send4(6); send4(7);
    a4.in_valid = 1;
    a4.in_data = 8;
    clear = 1;
    tick;
    clear = 0;
    a4.in_valid = 0;
    checks++;
    if (a4.out_valid !== 0 || busy4 !== 0 || a4.out_peak !== 0 || a4.out_idx !== 0 || a4.in_ready !== 1) begin
      errors++;
      $display("FAIL clear: vld=%b busy=%b peak=%0d idx=%0d rdy=%b want 0 0 0 0 1", a4.out_valid, busy4, a4.out_peak, a4.out_idx, a4.in_ready);
    end
    send4(1); send4(2); send4(3); send4(4);
    checks++;
    if (a4.out_valid !== 1 || a4.out_peak !== 4 || a4.out_idx !== 3) begin
      errors++;
      $display("FAIL clear_next: vld=%b peak=%0d idx=%0d want 1 4 3", a4.out_valid, a4.out_peak, a4.out_idx);
    end
    tick;
  endtask

  task automatic test_async_reset;
    a4.out_ready = 1;
    send4(9); send4(2);
    #2 rst_n = 0;
    #1;
    checks++;
    if (busy4 !== 0 || a4.out_peak !== 0 || a4.out_idx !== 0 || a4.in_ready !== 1 || a4.out_valid !== 0) begin
      errors++;
      $display("FAIL async_mid: busy=%b peak=%0d idx=%0d rdy=%b vld=%b want 0 0 0 1 0", busy4, a4.out_peak, a4.out_idx, a4.in_ready, a4.out_valid);
    end
    tick;
    rst_n = 1;
    tick;
    a4.out_ready = 0;
    send4(11); send4(4); send4(13); send4(6);
    #2 rst_n = 0;
    #1;
    checks++;
    if (a4.out_valid !== 0 || a4.out_peak !== 0 || a4.in_ready !== 1) begin
      errors++;
      $display("FAIL async_hold: vld=%b peak=%0d rdy=%b want 0 0 1", a4.out_valid, a4.out_peak, a4.in_ready);
    end
    tick;
    rst_n = 1;
    tick;
  endtask

  task automatic push2(input logic [3:0] d);
    repeat ($urandom_range(0, 2)) tick;
    a2.in_valid = 1;
    a2.in_data = d;
    tick;
    a2.in_valid = 0;
  endtask

  task automatic test_exhaustive;
    logic [3:0] x, y, pk;
    a2.out_ready = 1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        x = 4'(a);
        y = 4'(b);
        pk = x > y ? x : y;
        push2(x);
        push2(y);
        checks++;
        if (a2.out_valid !== 1 || a2.out_peak !== pk || a2.out_idx !== (y > x)) begin
          errors++;
          $display("FAIL pair(%0d,%0d): vld=%b peak=%0d idx=%0d want 1 %0d %0d", a, b, a2.out_valid, a2.out_peak, a2.out_idx, pk, y > x);
        end
        tick;
      end
  endtask

  task automatic test_random;
    logic [3:0] q[$];
    logic [3:0] ep[$];
    int ei[$];
    logic [3:0] em[$];
    logic [3:0] pk, mn;
    int ix;
    int n_in = 0, n_out = 0, cyc = 0;
    while (n_out < 1000 && cyc < 40000) begin
      a4.in_valid = $urandom_range(0, 2) != 0;
      a4.in_data = 4'($urandom);
      a4.out_ready = $urandom_range(0, 1) == 1;
      if (a4.in_valid && a4.in_ready) begin
        q.push_back(a4.in_data);
        n_in++;
        if (q.size() == 4) begin
          ref_win(q, pk, ix, mn);
          ep.push_back(pk); ei.push_back(ix); em.push_back(mn);
          q.delete();
        end
      end
      if (a4.out_valid && a4.out_ready) begin
        checks++;
        if (ep.size() != 1 || a4.out_peak !== ep[0] || int'(a4.out_idx) != ei[0]) begin
          errors++;
          $display("FAIL rand_win[%0d]: peak=%0d idx=%0d want %0d %0d (pending %0d)", n_out, a4.out_peak, a4.out_idx, ep[0], ei[0], ep.size());
        end
`ifdef PEAK_HOLD_MIN_EN
        checks++;
        if (a4.out_min !== em[0]) begin errors++; $display("FAIL rand_min[%0d]: got %0d want %0d", n_out, a4.out_min, em[0]); end
`endif
        if (ep.size() > 0) begin void'(ep.pop_front()); void'(ei.pop_front()); void'(em.pop_front()); end
        n_out++;
      end
      tick;
      cyc++;
    end
    a4.in_valid = 0;
    checks++;
    if (n_out != 1000) begin errors++; $display("FAIL rand_timeout: windows=%0d want 1000", n_out); end
    checks++;
    if (n_in != 4 * n_out) begin errors++; $display("FAIL rand_count: in=%0d want %0d", n_in, 4 * n_out); end
  endtask

  initial begin
    test_reset;
    test_tie;
    test_zeros;
    test_backpressure;
    test_clear;
    test_async_reset;
    test_exhaustive;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
